// File: rtl/fetch_unit.sv
// fetch_unit: program counter and single-outstanding instruction fetch stage with misalignment and timeout faults
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int TIMEOUT = 16
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] NEXT_PC,
  output logic [31:0] PC,
  output logic        HOLD,
  output logic        IMEM_REQ,
  output logic [31:0] IMEM_ADDR,
  input  logic        IMEM_ACK,
  input  logic [31:0] IMEM_RDATA,
  output logic [31:0] INSTR,
  output logic [31:0] INSTR_PC,
  output logic        INSTR_VALID,
  input  logic        INSTR_READY,
  input  logic        STALL,
  output logic        FAULT,
  output logic [1:0]  FAULT_CODE
);
  localparam int CW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT - 1);
  localparam logic [1:0] FETCH = 2'd0;
  localparam logic [1:0] HAVE = 2'd1;
  localparam logic [1:0] FAULTED = 2'd2;
  logic [1:0] state_q, state_d, code_q, code_d;
  logic [31:0] pc_q, pc_d, instr_q, instr_d, instr_pc_q, instr_pc_d;
  logic fault_q, fault_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic fetching, misal, transfer, expire;
  always_comb begin
    fetching = state_q == FETCH;
    misal = fetching && pc_q[1:0] != 2'b00;
    transfer = state_q == HAVE && INSTR_READY && !STALL;
    expire = TIMEOUT > 0 && cnt_q == TMAX;
    state_d = state_q;
    pc_d = pc_q;
    instr_d = instr_q;
    instr_pc_d = instr_pc_q;
    fault_d = fault_q;
    code_d = code_q;
    cnt_d = cnt_q;
    if (misal) begin
      state_d = FAULTED;
      fault_d = 1'b1;
      code_d = 2'b01;
    end else if (fetching && IMEM_ACK) begin
      state_d = HAVE;
      instr_d = IMEM_RDATA;
      instr_pc_d = pc_q;
    end else if (fetching && expire) begin
      state_d = FAULTED;
      fault_d = 1'b1;
      code_d = 2'b10;
    end else if (fetching) begin
      cnt_d = cnt_q + CW'(1);
    end else if (transfer) begin
      state_d = FETCH;
      pc_d = NEXT_PC;
      cnt_d = '0;
    end
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= FETCH;
      pc_q <= RESET_PC;
      instr_q <= '0;
      instr_pc_q <= '0;
      fault_q <= 1'b0;
      code_q <= 2'b00;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      instr_q <= instr_d;
      instr_pc_q <= instr_pc_d;
      fault_q <= fault_d;
      code_q <= code_d;
      cnt_q <= cnt_d;
    end
  end
  assign PC = pc_q;
  assign HOLD = !transfer;
  assign IMEM_REQ = fetching && !misal;
  assign IMEM_ADDR = pc_q;
  assign INSTR = instr_q;
  assign INSTR_PC = instr_pc_q;
  assign INSTR_VALID = state_q == HAVE;
  assign FAULT = fault_q;
  assign FAULT_CODE = code_q;
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed vector table, hand sequences and randomized transaction-level check of fetch_unit
module tb_fetch_unit;
  logic CLK = 1'b0;
  logic RST, IMEM_ACK, INSTR_READY, STALL;
  logic [31:0] NEXT_PC, IMEM_RDATA;
  logic [31:0] PC, IMEM_ADDR, INSTR, INSTR_PC;
  logic HOLD, IMEM_REQ, INSTR_VALID, FAULT;
  logic [1:0] FAULT_CODE;
  int nerr = 0;
  int nchk = 0;
  always #5 CLK = ~CLK;
  fetch_unit #(.RESET_PC(32'h0), .TIMEOUT(4)) dut (
    .CLK(CLK), .RST(RST), .NEXT_PC(NEXT_PC), .PC(PC), .HOLD(HOLD),
    .IMEM_REQ(IMEM_REQ), .IMEM_ADDR(IMEM_ADDR), .IMEM_ACK(IMEM_ACK), .IMEM_RDATA(IMEM_RDATA),
    .INSTR(INSTR), .INSTR_PC(INSTR_PC), .INSTR_VALID(INSTR_VALID), .INSTR_READY(INSTR_READY),
    .STALL(STALL), .FAULT(FAULT), .FAULT_CODE(FAULT_CODE)
  );
  typedef struct packed {
    logic ack, rdy, stl;
    logic [31:0] npc;
    logic e_req;
    logic [31:0] e_addr;
    logic e_vld;
    logic [31:0] e_ipc;
    logic e_hold, e_flt;
    logic [1:0] e_code;
    logic [31:0] e_pc;
  } vec_t;
  vec_t tbl [19];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask
  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction
  function automatic logic [31:0] pick(input logic [31:0] pc);
    int r;
    r = int'($urandom_range(0, 7));
    return r == 0 ? 32'hFFFF_FFFC : r < 3 ? ($urandom & 32'hFFFF_FFFC) : pc + 32'd4;
  endfunction
  task automatic do_reset;
    RST = 1'b1;
    IMEM_ACK = 1'b0;
    INSTR_READY = 1'b0;
    STALL = 1'b0;
    NEXT_PC = '0;
    IMEM_RDATA = '0;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
  endtask
  initial begin
    logic m_have, xfer, rdy, st;
    logic [31:0] exp_pc, tgt;
    int w, n;
    tbl[0]  = {1'b1, 1'b1, 1'b0, 32'h4,  1'b1, 32'h0,  1'b0, 32'h0,  1'b1, 1'b0, 2'd0, 32'h0};
    tbl[1]  = {1'b1, 1'b1, 1'b0, 32'h4,  1'b0, 32'h0,  1'b1, 32'h0,  1'b0, 1'b0, 2'd0, 32'h0};
    tbl[2]  = {1'b1, 1'b1, 1'b0, 32'h8,  1'b1, 32'h4,  1'b0, 32'h0,  1'b1, 1'b0, 2'd0, 32'h4};
    tbl[3]  = {1'b1, 1'b1, 1'b0, 32'h8,  1'b0, 32'h4,  1'b1, 32'h4,  1'b0, 1'b0, 2'd0, 32'h4};
    tbl[4]  = {1'b1, 1'b1, 1'b0, 32'h20, 1'b1, 32'h8,  1'b0, 32'h0,  1'b1, 1'b0, 2'd0, 32'h8};
    tbl[5]  = {1'b1, 1'b1, 1'b0, 32'h20, 1'b0, 32'h8,  1'b1, 32'h8,  1'b0, 1'b0, 2'd0, 32'h8};
    tbl[6]  = {1'b0, 1'b1, 1'b0, 32'h20, 1'b1, 32'h20, 1'b0, 32'h0,  1'b1, 1'b0, 2'd0, 32'h20};
    tbl[7]  = {1'b0, 1'b1, 1'b0, 32'h20, 1'b1, 32'h20, 1'b0, 32'h0,  1'b1, 1'b0, 2'd0, 32'h20};
    tbl[8]  = {1'b0, 1'b1, 1'b0, 32'h20, 1'b1, 32'h20, 1'b0, 32'h0,  1'b1, 1'b0, 2'd0, 32'h20};
    tbl[9]  = {1'b1, 1'b1, 1'b0, 32'h20, 1'b1, 32'h20, 1'b0, 32'h0,  1'b1, 1'b0, 2'd0, 32'h20};
    tbl[10] = {1'b1, 1'b1, 1'b1, 32'h24, 1'b0, 32'h20, 1'b1, 32'h20, 1'b1, 1'b0, 2'd0, 32'h20};
    tbl[11] = {1'b1, 1'b1, 1'b1, 32'h24, 1'b0, 32'h20, 1'b1, 32'h20, 1'b1, 1'b0, 2'd0, 32'h20};
    tbl[12] = {1'b0, 1'b0, 1'b0, 32'h24, 1'b0, 32'h20, 1'b1, 32'h20, 1'b1, 1'b0, 2'd0, 32'h20};
    tbl[13] = {1'b0, 1'b1, 1'b0, 32'h24, 1'b0, 32'h20, 1'b1, 32'h20, 1'b0, 1'b0, 2'd0, 32'h20};
    tbl[14] = {1'b1, 1'b1, 1'b0, 32'h28, 1'b1, 32'h24, 1'b0, 32'h0,  1'b1, 1'b0, 2'd0, 32'h24};
    tbl[15] = {1'b1, 1'b1, 1'b0, 32'h22, 1'b0, 32'h24, 1'b1, 32'h24, 1'b0, 1'b0, 2'd0, 32'h24};
    tbl[16] = {1'b1, 1'b1, 1'b0, 32'h22, 1'b0, 32'h22, 1'b0, 32'h0,  1'b1, 1'b0, 2'd0, 32'h22};
    tbl[17] = {1'b1, 1'b1, 1'b0, 32'h22, 1'b0, 32'h22, 1'b0, 32'h0,  1'b1, 1'b1, 2'd1, 32'h22};
    tbl[18] = {1'b1, 1'b1, 1'b0, 32'h22, 1'b0, 32'h22, 1'b0, 32'h0,  1'b1, 1'b1, 2'd1, 32'h22};
    do_reset();
    IMEM_ACK = 1'b1;
    IMEM_RDATA = 32'h0000_0013;
    NEXT_PC = 32'h4;
    #1;
    chk("rst_pc", PC, 32'h0);
    chk("rst_valid", 32'(INSTR_VALID), 32'h0);
    chk("rst_instr", INSTR, 32'h0);
    chk("rst_instr_pc", INSTR_PC, 32'h0);
    chk("rst_fault", 32'(FAULT), 32'h0);
    chk("rst_code", 32'(FAULT_CODE), 32'h0);
    chk("first_req", 32'(IMEM_REQ), 32'h1);
    chk("first_addr", IMEM_ADDR, 32'h0);
    @(negedge CLK);
    #1;
    chk("first_valid", 32'(INSTR_VALID), 32'h1);
    chk("first_instr", INSTR, 32'h0000_0013);
    chk("first_ipc", INSTR_PC, 32'h0);
    chk("first_hold", 32'(HOLD), 32'h1);
    @(negedge CLK);
    do_reset();
    for (int i = 0; i < 19; i++) begin
      IMEM_ACK = tbl[i].ack;
      INSTR_READY = tbl[i].rdy;
      STALL = tbl[i].stl;
      NEXT_PC = tbl[i].npc;
      IMEM_RDATA = mem(tbl[i].e_pc);
      #1;
      chk($sformatf("tbl%0d_req", i), 32'(IMEM_REQ), 32'(tbl[i].e_req));
      if (tbl[i].e_req) chk($sformatf("tbl%0d_addr", i), IMEM_ADDR, tbl[i].e_addr);
      chk($sformatf("tbl%0d_valid", i), 32'(INSTR_VALID), 32'(tbl[i].e_vld));
      if (tbl[i].e_vld) chk($sformatf("tbl%0d_ipc", i), INSTR_PC, tbl[i].e_ipc);
      if (tbl[i].e_vld) chk($sformatf("tbl%0d_instr", i), INSTR, mem(tbl[i].e_ipc));
      chk($sformatf("tbl%0d_hold", i), 32'(HOLD), 32'(tbl[i].e_hold));
      chk($sformatf("tbl%0d_fault", i), 32'(FAULT), 32'(tbl[i].e_flt));
      chk($sformatf("tbl%0d_code", i), 32'(FAULT_CODE), 32'(tbl[i].e_code));
      chk($sformatf("tbl%0d_pc", i), PC, tbl[i].e_pc);
      @(negedge CLK);
    end
    do_reset();
    #1;
    chk("fault_cleared", 32'(FAULT), 32'h0);
    chk("code_cleared", 32'(FAULT_CODE), 32'h0);
    n = 0;
    for (int c = 0; c < 20 && IMEM_REQ; c++) begin
      n++;
      chk("to_nofault_wait", 32'(FAULT), 32'h0);
      @(negedge CLK);
      #1;
    end
    chk("to_req_cycles", 32'(n), 32'h4);
    chk("to_fault", 32'(FAULT), 32'h1);
    chk("to_code", 32'(FAULT_CODE), 32'h2);
    IMEM_ACK = 1'b1;
    @(negedge CLK);
    #1;
    chk("to_sticky", 32'(FAULT), 32'h1);
    chk("to_req_low", 32'(IMEM_REQ), 32'h0);
    chk("to_hold", 32'(HOLD), 32'h1);
    @(negedge CLK);
    do_reset();
    IMEM_RDATA = 32'hCAFE_0000;
    repeat (3) @(negedge CLK);
    IMEM_ACK = 1'b1;
    #1;
    chk("ack4_req", 32'(IMEM_REQ), 32'h1);
    @(negedge CLK);
    IMEM_ACK = 1'b0;
    #1;
    chk("ack4_nofault", 32'(FAULT), 32'h0);
    chk("ack4_valid", 32'(INSTR_VALID), 32'h1);
    chk("ack4_instr", INSTR, 32'hCAFE_0000);
    @(negedge CLK);
    do_reset();
    IMEM_ACK = 1'b1;
    INSTR_READY = 1'b1;
    NEXT_PC = 32'h40;
    repeat (2) @(negedge CLK);
    IMEM_ACK = 1'b0;
    #1;
    chk("mid_pc", PC, 32'h40);
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    IMEM_ACK = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    IMEM_ACK = 1'b0;
    #1;
    chk("mid_rst_pc", PC, 32'h0);
    chk("mid_rst_valid", 32'(INSTR_VALID), 32'h0);
    for (int c = 0; c < 4; c++) begin
      chk("mid_rst_req", 32'(IMEM_REQ), 32'h1);
      chk("mid_rst_fault", 32'(FAULT), 32'h0);
      @(negedge CLK);
      #1;
    end
    @(negedge CLK);
    do_reset();
    m_have = 1'b0;
    exp_pc = 32'h0;
    tgt = pick(exp_pc);
    w = int'($urandom_range(0, 3));
    for (int c = 0; c < 800; c++) begin
      rdy = $urandom_range(0, 3) != 0;
      st = $urandom_range(0, 4) == 0;
      xfer = m_have && rdy && !st;
      INSTR_READY = rdy;
      STALL = st;
      NEXT_PC = xfer ? tgt : ($urandom & 32'hFFFF_FFFC);
      IMEM_ACK = m_have ? $urandom_range(0, 1) == 1 : w == 0;
      IMEM_RDATA = (!m_have && w == 0) ? mem(exp_pc) : $urandom;
      #1;
      if (!m_have) begin
        chk("rnd_req", 32'(IMEM_REQ), 32'h1);
        chk("rnd_addr", IMEM_ADDR, exp_pc);
        chk("rnd_valid_lo", 32'(INSTR_VALID), 32'h0);
        chk("rnd_hold_fetch", 32'(HOLD), 32'h1);
      end else begin
        chk("rnd_req_lo", 32'(IMEM_REQ), 32'h0);
        chk("rnd_valid", 32'(INSTR_VALID), 32'h1);
        chk("rnd_ipc", INSTR_PC, exp_pc);
        chk("rnd_instr", INSTR, mem(exp_pc));
        chk("rnd_hold", 32'(HOLD), 32'(!xfer));
      end
      chk("rnd_pc", PC, exp_pc);
      chk("rnd_fault", 32'(FAULT), 32'h0);
      if (!m_have) begin
        if (w == 0) m_have = 1'b1;
        else w--;
      end else if (xfer) begin
        m_have = 1'b0;
        exp_pc = tgt;
        tgt = pick(exp_pc);
        w = int'($urandom_range(0, 3));
      end
      @(negedge CLK);
    end
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Program-counter register and instruction-fetch stage.
- Sits directly downstream of the branch/next-PC logic:
  - consumes its next-PC value (NEXT_PC);
  - drives back the current PC and the HOLD request.
- Fetches one 32-bit instruction per PC over a request/acknowledge instruction-memory port.
- Presents the instruction to decode with a valid/ready handshake.
- Detects misaligned PCs and memory timeouts.

Parameters:
- RESET_PC, 32'h00000000, PC value loaded on reset.
- TIMEOUT, 16, max cycles IMEM_REQ may wait for IMEM_ACK before a fault; 0 disables the watchdog.

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  synchronous, active-high reset.
- NEXT_PC  in  32  next PC from branch logic (its INCR output).
- PC  out  32  current PC, fed to branch logic.
- HOLD  out  1  to branch logic; 1 whenever the PC is not advancing this cycle.
- IMEM_REQ  out  1  instruction read request.
- IMEM_ADDR  out  32  instruction read address.
- IMEM_ACK  in  1  read data valid this cycle.
- IMEM_RDATA  in  32  instruction word.
- INSTR  out  32  instruction to decode.
- INSTR_PC  out  32  PC of INSTR.
- INSTR_VALID  out  1  INSTR/INSTR_PC valid.
- INSTR_READY  in  1  decode accepts.
- STALL  in  1  downstream pipeline stall; blocks the handshake.
- FAULT  out  1  sticky fault flag.
- FAULT_CODE  out  2  00 none, 01 misaligned PC, 10 fetch timeout.

Behaviour:
- Reset (RST=1 at a rising edge):
  - PC=RESET_PC; state=FETCH; INSTR=0; INSTR_PC=0; INSTR_VALID=0; FAULT=0; FAULT_CODE=00; timeout counter=0.
  - Reset mid-operation abandons any outstanding request. The memory must drop IMEM_ACK while RST=1.
  - An ACK arriving while RST=1 is ignored.
- States:
  - FETCH: IMEM_REQ=1, IMEM_ADDR=PC, INSTR_VALID=0.
    - IMEM_ACK=1: INSTR<=IMEM_RDATA, INSTR_PC<=PC, go to HAVE.
    - Otherwise: counter++.
  - HAVE: IMEM_REQ=0, INSTR_VALID=1.
    - Transfer when INSTR_VALID & INSTR_READY & !STALL: PC<=NEXT_PC, counter<=0, go to FETCH.
    - Otherwise: hold all outputs stable.
  - FAULTED: IMEM_REQ=0, INSTR_VALID=0, HOLD=1. Exit only via RST.
- HOLD is combinational and equals !transfer. Branch logic then returns NEXT_PC=PC while not transferring.
- NEXT_PC is sampled only on the transfer cycle, so the branch target reflects the instruction being retired from fetch.
- Request rules:
  - IMEM_REQ and IMEM_ADDR stay stable from assertion until the ACK cycle inclusive.
  - An ACK seen while IMEM_REQ=0 is ignored.
  - One outstanding request maximum.
- Latency: an ACK in the same cycle as REQ gives INSTR_VALID the next cycle. Minimum 2 cycles per instruction.
- Misaligned PC:
  - In FETCH with PC[1:0]!=0: IMEM_REQ is forced to 0 combinationally.
  - Next edge: FAULT=1, FAULT_CODE=01, go to FAULTED.
  - Misalignment takes priority over ACK and timeout.
- Timeout (TIMEOUT>0):
  - The counter (width $clog2(TIMEOUT+1)) counts FETCH cycles without ACK.
  - When counter==TIMEOUT-1 and no ACK: FAULT=1, FAULT_CODE=10, go to FAULTED. REQ drops the following cycle.
  - An ACK in that same cycle wins: no fault.
- PC wrap: NEXT_PC=32'hFFFFFFFC followed by +4 gives 0, with no special handling.
- Simultaneous events:
  - STALL=1 with INSTR_READY=1: no transfer.
  - RST overrides everything.

Test Plan:
- Reset, then IMEM_ACK tied 1 with RDATA=32'h00000013 -> IMEM_ADDR=0 on the first cycle; INSTR_VALID=1 on the second cycle with INSTR_PC=0.
- Sequential fetch, NEXT_PC=PC+4, ACK same-cycle, READY=1 -> IMEM_ADDR sequence 0,4,8,C with one instruction every 2 cycles; HOLD=0 only on transfer cycles.
- Branch: at PC=8, NEXT_PC=32'h20 on the transfer cycle -> next IMEM_ADDR=32'h20, INSTR_PC=32'h20.
- Wait states: ACK delayed 3 cycles -> REQ/ADDR stable for 4 cycles; INSTR_VALID on the 5th cycle; no fault. STALL=1 for 2 cycles -> INSTR held, HOLD=1, PC unchanged.
- Misaligned: NEXT_PC=32'h22 -> IMEM_REQ never asserted for 0x22; FAULT=1, FAULT_CODE=01 one cycle later; stays until RST.
- Timeout: TIMEOUT=4, ACK never -> REQ high for 4 cycles; then FAULT=1, FAULT_CODE=10. Repeat with ACK on the 4th cycle -> no fault; RST mid-wait -> PC=RESET_PC, FAULT=0.
